// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage ahead of Fetch.
//
// Owns the fetch PC and issues one request at a time to instruction memory
// over a req/ack handshake. Returned {pc, instr} pairs land in a DEPTH-entry
// FIFO whose head is presented to Fetch/Decode. A redirect (taken branch or
// jump from Execute) flushes the FIFO and turns any in-flight request stale.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   imem_req/imem_addr    request outstanding / its address
//   imem_ack/imem_rdata   response strobe / instruction word
//   redirect/redirect_pc  taken branch/jump and its target
//   stall                 consumer not taking the head entry this cycle
//   instr_valid           FIFO not empty
//   instr/pc/pc_plus4     head entry (all zero when empty)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          pop, push, space;
  logic [CW-1:0] count_nxt;
  entry_t        head;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & ~stall & ~redirect;
  assign push        = imem_ack & (state_q == S_BUSY) & ~redirect;
  assign count_nxt   = count_q + CW'(push) - CW'(pop);
  // Issue only when the slot is guaranteed: with a single outstanding
  // request this is enough to make every accepted response fit.
  assign space       = (count_nxt < CW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    // Track the live request address so DROP can keep presenting it after
    // fpc has already moved to the redirect target.
    addr_d   = (state_q == S_BUSY) ? fpc_q : addr_q;

    if (redirect) begin
      fpc_d    = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      unique case (state_q)
        S_BUSY:  state_d = imem_ack ? S_IDLE : S_DROP;
        S_DROP:  state_d = imem_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fpc_q, instr: imem_rdata};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        fpc_d           = fpc_q + 32'd4;
      end
      count_d = count_nxt;
      unique case (state_q)
        S_IDLE:  state_d = space ? S_BUSY : S_IDLE;
        S_BUSY:  if (imem_ack) state_d = space ? S_BUSY : S_IDLE;
        S_DROP:  if (imem_ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign imem_req  = (state_q == S_BUSY) | (state_q == S_DROP);
  assign imem_addr = (state_q == S_BUSY) ? fpc_q : addr_q;

  // Head is purely registered state; imem_rdata never reaches it directly.
  assign head     = mem_q[rd_ptr_q];
  assign instr    = instr_valid ? head.instr : 32'h0;
  assign pc       = instr_valid ? head.pc : 32'h0;
  assign pc_plus4 = instr_valid ? (head.pc + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue.
//
// The reference model treats the fetch stream abstractly: a sequential PC
// counter restarted by redirects, a queue of expected {pc, instr} entries and
// a stale flag for a request overtaken by a redirect. The driver pushes an
// expected entry whenever memory answers a live request; the monitor compares
// and pops whenever the DUT presents its head.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          consumed = 0;
  logic        stale = 1'b0;
  logic [31:0] mfpc = RESET_PC;
  logic        req_s = 1'b0;
  logic [31:0] addr_s = '0;
  int          pack, pstall, predir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented head against the scoreboard, pop on accept.
  always @(negedge clk) begin
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("pc", pc, exp_q[0].pc);
      chk("instr", instr, exp_q[0].instr);
      chk("pc_plus4", pc_plus4, exp_q[0].pc + 32'd4);
      if (reset && !stall && !redirect) begin
        void'(exp_q.pop_front());
        consumed++;
      end
    end else begin
      chk("empty_instr", instr, 32'h0);
      chk("empty_pc", pc, 32'h0);
      chk("empty_pc_plus4", pc_plus4, 32'h0);
    end
  end

  // One clock: account for what the edge did, then drive the next inputs.
  task automatic drive_cycle();
    logic stab;
    @(posedge clk);
    stab = reset && req_s && !imem_ack;
    if (reset) begin
      if (req_s) begin
        if (imem_ack) begin
          if (!stale && !redirect) begin
            chk("no_overflow", {31'b0, exp_q.size() < DEPTH}, 32'd1);
            exp_q.push_back('{pc: addr_s, instr: mem_word(addr_s)});
            mfpc = addr_s + 32'd4;
          end
          stale = 1'b0;
        end else if (redirect) begin
          stale = 1'b1;
        end
      end
      if (redirect) begin
        exp_q.delete();
        mfpc = {redirect_pc[31:2], 2'b00};
      end
    end
    #1;
    if (stab && imem_req) chk("addr_stable", imem_addr, addr_s);
    req_s  = imem_req;
    addr_s = imem_addr;
    if (req_s && !stale) chk("fetch_addr", addr_s, mfpc);
    imem_ack    = req_s && ($urandom % 100 < pack);
    imem_rdata  = imem_ack ? mem_word(addr_s) : $urandom;
    stall       = ($urandom % 100) < pstall;
    redirect    = ($urandom % 100) < predir;
    redirect_pc = $urandom;
  endtask

  task automatic run(input int n, input int a, input int s, input int r);
    pack = a; pstall = s; predir = r;
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  // Assert reset asynchronously between edges, hold, release.
  task automatic do_reset(input int n);
    reset = 1'b0;
    exp_q.delete();
    mfpc = RESET_PC; stale = 1'b0; req_s = 1'b0;
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    // A leftover response right after release must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    int c0;
    #2;
    do_reset(3);
    pack = 100; pstall = 0; predir = 0;
    drive_cycle();
    chk("req_after_reset", {31'b0, imem_req}, 32'd1);
    chk("addr_after_reset", imem_addr, RESET_PC);

    // Zero-wait streaming: one instruction per cycle.
    c0 = consumed;
    run(40, 100, 0, 0);
    chk("stream_rate", {31'b0, (consumed - c0) >= 37}, 32'd1);

    // Fill with consumer stalled: FIFO full, no further request.
    run(12, 100, 100, 0);
    chk("full_count", exp_q.size(), DEPTH);
    chk("full_no_req", {31'b0, imem_req}, 32'd0);
    run(1, 100, 0, 0);
    run(6, 100, 0, 0);

    // Slow memory with redirects while requests are pending.
    run(200, 25, 10, 6);

    for (int seg = 0; seg < 8; seg++)
      run(300, $urandom_range(10, 100), $urandom_range(0, 80), $urandom_range(0, 10));

    // Build up entries with a pending request, then reset mid-operation.
    run(6, 100, 100, 0);
    run(1, 0, 100, 0);
    @(posedge clk);
    #2;
    do_reset(2);
    pack = 60; pstall = 20; predir = 3;
    drive_cycle();
    chk("req_after_midreset", {31'b0, imem_req}, 32'd1);
    chk("addr_after_midreset", imem_addr, RESET_PC);
    run(300, 60, 20, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
